// File: rtl/me_stage_if.sv
// Data-cache port between the memory stage and the cache.
// master: req/we/addr/wdata/be out, ready/rdata in.
interface me_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );
endinterface

// File: rtl/me_stage.sv
// Memory-access stage: cache load/store, load formatting,
// PC redirect resolution and the ME/WB pipeline register.
// Ports: clk, rst (sync, active high); me_* controls from EX/ME;
// dmem (cache port, master); me_stall; pc_redirect/pc_target;
// misalign and wb_* (registered ME/WB outputs).
module me_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        me_write_reg_enable,
    input  logic        me_wb_aluOut_or_memOut,
    input  logic [1:0]  me_write_ram_flag,
    input  logic [2:0]  me_load_ram_flag,
    input  logic [1:0]  me_pc_condition,
    input  logic        me_branch_enable,
    input  logic [31:0] me_pc_add_imm_32,
    input  logic [31:0] me_rs1_data_add_imm_32_for_pc,
    input  logic [31:0] me_alu_out,
    input  logic [31:0] me_rs2_data,
    input  logic [4:0]  me_rd_addr,
    input  logic [4:0]  me_rs2_addr,
    me_stage_if.master  dmem,
    output logic        me_stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        misalign,
    output logic        wb_write_reg_enable,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rs2_addr
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;

    logic       is_store;
    logic       is_load;
    logic       access;
    logic       sz_b;
    logic       sz_h;
    logic       sz_w;
    logic [1:0] off;
    logic       mis;
    logic       go;
    logic       req;
    logic [3:0] be_base;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign off      = me_alu_out[1:0];
    assign is_store = me_write_ram_flag != 2'd0;
    assign is_load  = (me_load_ram_flag != 3'd0)
                    && (me_load_ram_flag <= 3'd5);
    assign access   = is_store || is_load;

    // Access size; a store wins over a simultaneous load.
    always_comb begin
        sz_b = 1'b0;
        sz_h = 1'b0;
        sz_w = 1'b0;
        if (is_store) begin
            unique case (me_write_ram_flag)
                2'd1:    sz_b = 1'b1;
                2'd2:    sz_h = 1'b1;
                default: sz_w = 1'b1;
            endcase
        end else begin
            unique case (me_load_ram_flag)
                3'd1, 3'd2: sz_b = 1'b1;
                3'd3, 3'd4: sz_h = 1'b1;
                default:    sz_w = 1'b1;
            endcase
        end
    end

    assign mis = access
              && ((sz_h && off[0]) || (sz_w && off != 2'd0));
    assign go  = access && !mis;

    // WAIT keeps the request up; the me_* inputs are frozen
    // by the stall, so go is still true there as well.
    assign req      = !rst && (go || state == S_WAIT);
    assign me_stall = req && !dmem.ready;

    assign dmem.req  = req;
    assign dmem.we   = req && is_store;
    assign dmem.addr = {me_alu_out[31:2], 2'b00};

    always_comb begin
        be_base = 4'b1111;
        unique case (1'b1)
            sz_b:    be_base = 4'b0001;
            sz_h:    be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign dmem.be = sz_w ? 4'b1111 : (be_base << off);

    always_comb begin
        dmem.wdata = me_rs2_data;
        unique case (1'b1)
            sz_b:    dmem.wdata = {4{me_rs2_data[7:0]}};
            sz_h:    dmem.wdata = {2{me_rs2_data[15:0]}};
            default: dmem.wdata = me_rs2_data;
        endcase
    end

    assign ld_byte = dmem.rdata[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? dmem.rdata[31:16]
                            : dmem.rdata[15:0];

    always_comb begin
        ld_data = dmem.rdata;
        unique case (me_load_ram_flag)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = dmem.rdata;
        endcase
    end

    // Redirect only when the instruction actually leaves ME.
    always_comb begin
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        if (!rst && !me_stall) begin
            unique case (me_pc_condition)
                2'd1: begin
                    if (me_branch_enable) begin
                        pc_redirect = 1'b1;
                        pc_target   = me_pc_add_imm_32;
                    end
                end
                2'd2: begin
                    pc_redirect = 1'b1;
                    pc_target   = me_pc_add_imm_32;
                end
                2'd3: begin
                    pc_redirect = 1'b1;
                    pc_target   = me_rs1_data_add_imm_32_for_pc
                                & ~32'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            misalign            <= 1'b0;
            wb_write_reg_enable <= 1'b0;
            wb_rd_addr          <= 5'd0;
            wb_data             <= 32'd0;
            wb_rs2_addr         <= 5'd0;
        end else begin
            unique case (state)
                S_IDLE:
                    if (go && !dmem.ready) state <= S_WAIT;
                S_WAIT:
                    if (dmem.ready) state <= S_IDLE;
            endcase
            if (me_stall) begin
                misalign            <= 1'b0;
                wb_write_reg_enable <= 1'b0;
                wb_rd_addr          <= 5'd0;
                wb_data             <= 32'd0;
                wb_rs2_addr         <= 5'd0;
            end else begin
                misalign            <= mis;
                wb_write_reg_enable <= me_write_reg_enable && !mis;
                wb_rd_addr          <= me_rd_addr;
                wb_data             <= me_wb_aluOut_or_memOut
                                     ? ld_data : me_alu_out;
                wb_rs2_addr         <= me_rs2_addr;
            end
        end
    end

endmodule
